adc_spi_config_ctrl: RTL and testbench

//   Configuration sequencer for the AD9284 over its 4-wire SPI port (ADC_SPI_CLK/CSB/SDO/SDI).

---
 rtl/adc_spi_pkg.sv | 41 ++++
 rtl/adc_spi_shift_engine.sv | 113 +++++++++++
 rtl/adc_spi_config_ctrl.sv | 104 ++++++++++
 tb/tb_adc_spi_config_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: AD9284 SPI frame layout, engine state encoding and the power-up init table
package adc_spi_pkg;
  localparam int FRAME_W  = 24;
  localparam int RW_BIT   = 23;
  localparam int ADDR_MSB = 20;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 8;
  localparam logic SPI_READ  = 1'b1;
  localparam logic SPI_WRITE = 1'b0;
  localparam int INIT_LEN = 4;
  localparam int IDX_W    = $clog2(INIT_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_GAP
  } spi_state_e;

  // W1:W0 stay 00: every frame moves a single data byte
  function automatic logic [FRAME_W-1:0] make_frame(input logic rw, input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[RW_BIT] = rw;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:0] = data;
    return f;
  endfunction

  // normal power mode, LVDS output, then transfer to latch the shadow registers
  function automatic logic [FRAME_W-1:0] init_frame(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(0) ? make_frame(SPI_WRITE, 13'h000, 8'h18) :
           idx == IDX_W'(1) ? make_frame(SPI_WRITE, 13'h008, 8'h00) :
           idx == IDX_W'(2) ? make_frame(SPI_WRITE, 13'h014, 8'h00) :
                              make_frame(SPI_WRITE, 13'h0FF, 8'h01);
  endfunction
endpackage

// File: rtl/adc_spi_shift_engine.sv
// adc_spi_shift_engine: one 24-bit mode-0 SPI frame (CS setup, shift, CS hold, CSB gap)
//   start/tx_frame : launch a frame, accepted in IDLE or on the last GAP cycle
//   done           : high on the last GAP cycle of a frame
//   busy           : engine not idle
//   rx_byte        : last 8 bits sampled on sclk rising edges
//   spi_*          : registered SPI pins
module adc_spi_shift_engine import adc_spi_pkg::*; #(
  parameter int unsigned CLK_HALF_DIV = 4,
  parameter int unsigned CSB_GAP      = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] tx_frame,
  output logic               done,
  output logic               busy,
  output logic [7:0]         rx_byte,
  output logic               spi_sclk,
  output logic               spi_csb,
  output logic               spi_sdo,
  input  logic               spi_sdi
);
  spi_state_e state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [4:0] bit_cnt, bit_n;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic [7:0] rx_n;
  logic sclk_n, csb_n, sdo_n, half_end;

  assign half_end = cnt == 16'(CLK_HALF_DIV - 1);
  assign done = state == ST_GAP && cnt == 16'(CSB_GAP - 1);
  assign busy = state != ST_IDLE;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      rx_byte <= '0;
      spi_sclk <= 1'b0;
      spi_csb <= 1'b1;
      spi_sdo <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      shreg <= shreg_n;
      rx_byte <= rx_n;
      spi_sclk <= sclk_n;
      spi_csb <= csb_n;
      spi_sdo <= sdo_n;
    end

  // Pins are computed one cycle ahead and registered so they never glitch.
  // Accepting start on the last GAP cycle lets frames run back to back.
  always_comb begin
    state_n = state;
    cnt_n = cnt + 16'd1;
    bit_n = bit_cnt;
    shreg_n = shreg;
    rx_n = rx_byte;
    sclk_n = spi_sclk;
    csb_n = spi_csb;
    sdo_n = spi_sdo;
    if (start && (state == ST_IDLE || done)) begin
      state_n = ST_CS_SETUP;
      cnt_n = '0;
      bit_n = '0;
      shreg_n = tx_frame;
      csb_n = 1'b0;
      sclk_n = 1'b0;
      sdo_n = tx_frame[FRAME_W-1];
    end else begin
      case (state)
        ST_CS_SETUP:
          if (half_end) begin
            state_n = ST_SHIFT;
            cnt_n = '0;
            sclk_n = 1'b1;
            rx_n = {rx_byte[6:0], spi_sdi};
          end
        ST_SHIFT:
          if (half_end) begin
            cnt_n = '0;
            if (spi_sclk) begin
              sclk_n = 1'b0;
              bit_n = bit_cnt + 5'd1;
              shreg_n = {shreg[FRAME_W-2:0], 1'b0};
              sdo_n = shreg[FRAME_W-2];
            end else if (bit_cnt == 5'(FRAME_W)) begin
              state_n = ST_CS_HOLD;
            end else begin
              sclk_n = 1'b1;
              rx_n = {rx_byte[6:0], spi_sdi};
            end
          end
        ST_CS_HOLD:
          if (half_end) begin
            state_n = ST_GAP;
            cnt_n = '0;
            csb_n = 1'b1;
          end
        ST_GAP:
          if (done) begin
            state_n = ST_IDLE;
            cnt_n = '0;
          end
        default: cnt_n = '0;
      endcase
    end
  end
endmodule

// File: rtl/adc_spi_config_ctrl.sv
// adc_spi_config_ctrl: AD9284 SPI configuration sequencer (init table + host register access)
//   start_init/init_done : (re)run the init table / table completed
//   busy                 : frame or init sequence in progress
//   req_* / rsp_*        : single host register read/write with response pulse
//   spi_*                : AD9284 4-wire SPI pins
module adc_spi_config_ctrl import adc_spi_pkg::*; #(
  parameter int unsigned CLK_HALF_DIV = 4,
  parameter int unsigned CSB_GAP      = 8,
  parameter bit          AUTO_INIT    = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_init,
  output logic              init_done,
  output logic              busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              spi_sclk,
  output logic              spi_csb,
  output logic              spi_sdo,
  input  logic              spi_sdi
);
  logic init_run, host_run, init_pending, run_en, host_rw;
  logic [IDX_W-1:0] idx;
  logic eng_start, eng_done, eng_busy;
  logic [7:0] eng_rx;
  logic [FRAME_W-1:0] eng_frame;
  logic top_idle, init_go, host_go, init_last, init_next;

  // start_init gates req_ready combinationally so init wins a same-cycle tie
  assign top_idle = !init_run && !host_run;
  assign init_go = top_idle && (init_pending || start_init);
  assign req_ready = run_en && top_idle && !init_pending && !start_init;
  assign host_go = req_valid && req_ready;
  assign init_last = idx == IDX_W'(INIT_LEN - 1);
  assign init_next = eng_done && init_run && !init_last;
  assign eng_start = init_go || host_go || init_next;
  assign busy = init_run || host_run || eng_busy;
  assign eng_frame = host_go ? make_frame(req_rw, req_addr, req_rw ? 8'h00 : req_wdata) :
                     init_frame(init_go ? '0 : IDX_W'(idx + 1'b1));

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      run_en <= 1'b0;
      init_pending <= AUTO_INIT;
      init_run <= 1'b0;
      init_done <= 1'b0;
      idx <= '0;
      host_run <= 1'b0;
      host_rw <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      run_en <= 1'b1;
      rsp_valid <= 1'b0;
      if (init_go) begin
        init_run <= 1'b1;
        init_pending <= 1'b0;
        init_done <= 1'b0;
        idx <= '0;
      end else if (start_init) begin
        init_pending <= 1'b1;
      end
      if (host_go) begin
        host_run <= 1'b1;
        host_rw <= req_rw;
      end
      if (eng_done && init_run) begin
        if (init_last) begin
          init_run <= 1'b0;
          init_done <= 1'b1;
        end else begin
          idx <= IDX_W'(idx + 1'b1);
        end
      end
      if (eng_done && host_run) begin
        host_run <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_rdata <= host_rw ? eng_rx : 8'h00;
      end
    end

  adc_spi_shift_engine #(
    .CLK_HALF_DIV(CLK_HALF_DIV),
    .CSB_GAP     (CSB_GAP)
  ) u_engine (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (eng_start),
    .tx_frame(eng_frame),
    .done    (eng_done),
    .busy    (eng_busy),
    .rx_byte (eng_rx),
    .spi_sclk(spi_sclk),
    .spi_csb (spi_csb),
    .spi_sdo (spi_sdo),
    .spi_sdi (spi_sdi)
  );
endmodule

// File: tb/tb_adc_spi_config_ctrl.sv
// tb_adc_spi_config_ctrl: scoreboard bench with an SPI slave model for adc_spi_config_ctrl
module tb_adc_spi_config_ctrl;
  logic clock = 1'b0;
  logic reset_n;
  logic start_init, req_valid, req_rw;
  logic [12:0] req_addr;
  logic [7:0] req_wdata;
  logic init_done, busy, req_ready, rsp_valid;
  logic [7:0] rsp_rdata;
  logic spi_sclk, spi_csb, spi_sdo;
  logic sdi = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc = 0;
  int rel = 0;
  int n = 0;
  logic prev_csb = 1'b1;
  logic prev_sclk = 1'b0;
  logic [23:0] sh = '0;
  logic [7:0] slave_byte = '0;
  logic [23:0] exp_frames[$];
  logic [7:0] exp_rsp[$];

  adc_spi_config_ctrl #(
    .CLK_HALF_DIV(4),
    .CSB_GAP     (8),
    .AUTO_INIT   (1'b1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start_init(start_init),
    .init_done (init_done),
    .busy      (busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .spi_sclk  (spi_sclk),
    .spi_csb   (spi_csb),
    .spi_sdo   (spi_sdo),
    .spi_sdi   (sdi)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Mode-0 slave: samples sdo on sclk rise, drives the read byte on falls 16..23
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_csb = 1'b1;
      prev_sclk = 1'b0;
      n = 0;
      sh = '0;
      sdi = 1'b0;
    end else begin
      if (prev_csb && !spi_csb) begin
        n = 0;
        sh = '0;
        sdi = 1'b0;
      end
      if (!spi_csb && spi_sclk && !prev_sclk) begin
        sh = {sh[22:0], spi_sdo};
        n++;
      end
      if (!spi_csb && !spi_sclk && prev_sclk && n >= 16 && n <= 23) sdi = slave_byte[3'(23 - n)];
      if (!prev_csb && spi_csb) begin
        chk("frame_expected", 32'(exp_frames.size() != 0), 1);
        if (exp_frames.size() != 0) begin
          chk("frame", 32'(sh), 32'(exp_frames.pop_front()));
          chk("frame_edges", n, 24);
        end
      end
      if (rsp_valid) begin
        chk("rsp_expected", 32'(exp_rsp.size() != 0), 1);
        if (exp_rsp.size() != 0) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rsp.pop_front()));
      end
      prev_csb = spi_csb;
      prev_sclk = spi_sclk;
    end
  end

  task automatic push_init();
    exp_frames.push_back(24'h000018);
    exp_frames.push_back(24'h000800);
    exp_frames.push_back(24'h001400);
    exp_frames.push_back(24'h00FF01);
  endtask

  task automatic host(input logic rw, input logic [12:0] a, input logic [7:0] d, input logic [7:0] sb);
    exp_frames.push_back({rw, 2'b00, a, rw ? 8'h00 : d});
    exp_rsp.push_back(rw ? sb : 8'h00);
    slave_byte = sb;
    req_valid = 1'b1;
    req_rw = rw;
    req_addr = a;
    req_wdata = d;
  endtask

  task automatic wait_init(input string tag, input int t0);
    int k = 0;
    int d;
    logic rdy = 1'b0;
    while (!init_done && k < 2000) begin
      @(negedge clock);
      k++;
      if (!init_done && req_ready) rdy = 1'b1;
    end
    d = cyc - t0;
    chk({tag, "_init_done"}, 32'(init_done), 1);
    chk({tag, "_ready_low_in_init"}, 32'(rdy), 0);
    n_chk++;
    assert (d >= 830 && d <= 834) n_pass++;
    else $error("FAIL %s_init_latency: got %0d cycles expected 832+/-2", tag, d);
    chk({tag, "_ready_first"}, 32'(req_ready), 1);
  endtask

  task automatic accept_and_wait(input string tag);
    int k = 0;
    #1;
    while (!req_ready && k < 1000) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 1);
    acc = cyc + 1;
    @(negedge clock);
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_addr = '1;
    req_wdata = '1;
    k = 0;
    while (!rsp_valid && k < 1000) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_rsp_latency"}, cyc - acc, 208);
    @(negedge clock);
    chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    start_init = 1'b0;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(negedge clock);
    chk("rst_csb", 32'(spi_csb), 1);
    chk("rst_sclk", 32'(spi_sclk), 0);
    chk("rst_sdo", 32'(spi_sdo), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_req_ready", 32'(req_ready), 0);

    push_init();
    reset_n = 1'b1;
    rel = cyc;
    wait_init("t1", rel);
    chk("t1_frames_done", exp_frames.size(), 0);

    @(negedge clock);
    host(1'b0, 13'h00D, 8'h04, 8'h00);
    accept_and_wait("t2");

    host(1'b1, 13'h001, 8'h00, 8'hA5);
    accept_and_wait("t3");

    push_init();
    start_init = 1'b1;
    host(1'b0, 13'h0C3, 8'h77, 8'h00);
    rel = cyc;
    #1;
    chk("t6_ready_blocked", 32'(req_ready), 0);
    @(negedge clock);
    start_init = 1'b0;
    chk("t6_init_done_clr", 32'(init_done), 0);
    chk("t6_busy", 32'(busy), 1);
    wait_init("t6", rel);
    accept_and_wait("t6");

    host(1'b0, 13'h100, 8'h3C, 8'h00);
    #1;
    chk("t5_ready", 32'(req_ready), 1);
    @(negedge clock);
    req_valid = 1'b0;
    k = 0;
    while (n < 10 && k < 500) begin
      @(negedge clock);
      k++;
    end
    chk("t5_in_frame", 32'(spi_csb), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_csb", 32'(spi_csb), 1);
    chk("t5_async_sclk", 32'(spi_sclk), 0);
    chk("t5_async_sdo", 32'(spi_sdo), 0);
    exp_frames.delete();
    exp_rsp.delete();
    repeat (2) @(negedge clock);
    chk("t5_rst_busy", 32'(busy), 0);
    push_init();
    host(1'b1, 13'h055, 8'h00, 8'h3C);
    @(negedge clock);
    reset_n = 1'b1;
    rel = cyc;
    wait_init("t5", rel);
    accept_and_wait("t5");

    repeat (20) @(negedge clock);
    chk("end_frames_empty", exp_frames.size(), 0);
    chk("end_rsp_empty", exp_rsp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
